// File: rtl/row_op_sched_pkg.sv
// Shared types and helpers for the post-placement row sequencer.
package row_op_sched_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int BOARD_BITS = BOARD_ROWS * BOARD_COLS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        FLASH   = 3'd2,
        COMPACT = 3'd3,
        ATTACK  = 3'd4,
        GARB    = 3'd5,
        FIN     = 3'd6
    } state_t;

    // Outgoing attack before cancellation; anything above four clears counts as four.
    function automatic logic [2:0] attack_raw(input logic [2:0] cleared);
        case (cleared)
            3'd0, 3'd1: return 3'd0;
            3'd2:       return 3'd1;
            3'd3:       return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

    function automatic logic [BOARD_COLS-1:0] board_row(input logic [BOARD_BITS-1:0] board,
                                                        input logic [4:0] r);
        return board[int'(r)*BOARD_COLS +: BOARD_COLS];
    endfunction

endpackage

// File: rtl/row_op_sched_row_full_detect.sv
// Combinational full-row detector: per-row AND plus a saturating popcount.
module row_full_detect
    import row_op_sched_pkg::*;
(
    input  logic [BOARD_BITS-1:0] board,
    output logic [BOARD_ROWS-1:0] mask,
    output logic [2:0]            count
);

    logic [4:0] total;

    always_comb begin
        mask  = '0;
        total = '0;
        for (int r = 0; r < BOARD_ROWS; r++) begin
            mask[r] = &board[r*BOARD_COLS +: BOARD_COLS];
            total   = total + {4'b0, mask[r]};
        end
        count = (total > 5'd7) ? 3'd7 : total[2:0];
    end

endmodule

// File: rtl/row_op_sched.sv
// Board sequencer: detect/flash/compact cleared rows, or insert pending garbage,
// and settle the garbage/attack exchange after each placement.
//
// state   | meaning
// IDLE    | waiting for start; snapshot taken on start
// SCAN    | latch full-row mask and clear count
// FLASH   | drive elimination_enable for FLASH_CYCLES cycles
// COMPACT | 20 writes, dst 19..0, skipping full source rows
// ATTACK  | cancel pending garbage, emit attack, size garbage insert
// GARB    | 20 writes, dst 0..19, board shifted up by g rows
// FIN     | last busy cycle; done pulses on the way to IDLE
module row_op_sched
    import row_op_sched_pkg::*;
#(
    parameter int FLASH_CYCLES = 25_000_000,
    parameter int MAX_PENDING  = 20,
    parameter int MAX_INSERT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BOARD_BITS-1:0] occupied_bind,
    input  logic                  garb_in_valid,
    input  logic [4:0]            garb_in_lines,
    input  logic [3:0]            garb_hole,
    output logic                  row_we,
    output logic [4:0]            row_addr,
    output logic [9:0]            row_wdata,
    output logic [BOARD_ROWS-1:0] elimination_enable,
    output logic [2:0]            lines_cleared,
    output logic [4:0]            garb_pending,
    output logic                  attack_valid,
    output logic [2:0]            attack_lines,
    output logic                  busy,
    output logic                  done,
    output logic                  topout
);

    state_t                  state_q, state_d;
    logic [BOARD_BITS-1:0]   snap_q;
    logic [BOARD_ROWS-1:0]   mask_q, scan_mask;
    logic [2:0]              lines_q, scan_count;
    logic [24:0]             flash_cnt_q;
    logic [4:0]              row_cnt_q, src_q, src_sel;
    logic                    src_live_q, src_found;
    logic [3:0]              g_q, hole_q;
    logic [4:0]              pend_q, pend_after, pend_base, pend_next, insert5, cancel5;
    logic [5:0]              sum6;
    logic [2:0]              raw, atk;
    logic                    go_garb;

    row_full_detect u_detect (
        .board (snap_q),
        .mask  (scan_mask),
        .count (scan_count)
    );

    // Highest non-full row at or below the source pointer.
    always_comb begin
        src_found = 1'b0;
        src_sel   = '0;
        for (int r = 0; r < BOARD_ROWS; r++) begin
            if (src_live_q && (5'(r) <= src_q) && !mask_q[r]) begin
                src_found = 1'b1;
                src_sel   = 5'(r);
            end
        end
    end

    // Pending update: cancellation, then garbage removal, then add, then saturate.
    always_comb begin
        raw        = attack_raw(lines_q);
        cancel5    = ({2'b0, raw} < pend_q) ? {2'b0, raw} : pend_q;
        pend_after = pend_q - cancel5;
        atk        = raw - cancel5[2:0];
        insert5    = (pend_after < 5'(MAX_INSERT)) ? pend_after : 5'(MAX_INSERT);
        go_garb    = (lines_q == 3'd0) && (pend_after != 5'd0);
        pend_base  = pend_q;
        if (state_q == ATTACK)
            pend_base = go_garb ? (pend_after - insert5) : pend_after;
        sum6       = {1'b0, pend_base} + (garb_in_valid ? {1'b0, garb_in_lines} : 6'd0);
        pend_next  = (sum6 > 6'(MAX_PENDING)) ? 5'(MAX_PENDING) : sum6[4:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    state_d = (scan_mask != '0) ? FLASH : ATTACK;
            FLASH:   if (flash_cnt_q == 25'd0) state_d = COMPACT;
            COMPACT: if (row_cnt_q == 5'd0) state_d = ATTACK;
            ATTACK:  state_d = go_garb ? GARB : FIN;
            GARB:    if (row_cnt_q == 5'd19) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q      <= '0;
            mask_q      <= '0;
            lines_q     <= '0;
            flash_cnt_q <= '0;
            row_cnt_q   <= '0;
            src_q       <= '0;
            src_live_q  <= 1'b0;
            g_q         <= '0;
            hole_q      <= '0;
            pend_q      <= '0;
            topout      <= 1'b0;
            done        <= 1'b0;
        end else begin
            done   <= (state_q == FIN);
            pend_q <= pend_next;
            case (state_q)
                IDLE: if (start) snap_q <= occupied_bind;
                SCAN: begin
                    mask_q      <= scan_mask;
                    lines_q     <= scan_count;
                    flash_cnt_q <= 25'(FLASH_CYCLES - 1);
                    row_cnt_q   <= 5'd19;
                    src_q       <= 5'd19;
                    src_live_q  <= 1'b1;
                end
                FLASH: if (flash_cnt_q != 25'd0) flash_cnt_q <= flash_cnt_q - 25'd1;
                COMPACT: begin
                    row_cnt_q <= row_cnt_q - 5'd1;
                    if (src_found && src_sel != 5'd0)
                        src_q <= src_sel - 5'd1;
                    else
                        src_live_q <= 1'b0;
                end
                ATTACK: begin
                    g_q       <= insert5[3:0];
                    hole_q    <= (garb_hole > 4'd9) ? 4'd9 : garb_hole;
                    row_cnt_q <= 5'd0;
                end
                GARB: begin
                    if (row_cnt_q < {1'b0, g_q} && board_row(snap_q, row_cnt_q) != '0)
                        topout <= 1'b1;
                    row_cnt_q <= row_cnt_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        row_we             = 1'b0;
        row_addr           = '0;
        row_wdata          = '0;
        elimination_enable = '0;
        attack_valid       = 1'b0;
        attack_lines       = '0;
        busy               = (state_q != IDLE);
        case (state_q)
            FLASH: elimination_enable = mask_q;
            COMPACT: begin
                row_we    = 1'b1;
                row_addr  = row_cnt_q;
                row_wdata = src_found ? board_row(snap_q, src_sel) : '0;
            end
            ATTACK: begin
                if (atk != 3'd0) begin
                    attack_valid = 1'b1;
                    attack_lines = atk;
                end
            end
            GARB: begin
                row_we   = 1'b1;
                row_addr = row_cnt_q;
                if (({1'b0, row_cnt_q} + {2'b0, g_q}) < 6'd20)
                    row_wdata = board_row(snap_q, row_cnt_q + {1'b0, g_q});
                else
                    row_wdata = ~(10'd1 << hole_q);
            end
            default: ;
        endcase
    end

    assign lines_cleared = lines_q;
    assign garb_pending  = pend_q;

endmodule

// File: tb/tb_row_op_sched.sv
// Directed bench for row_op_sched: vector table plus hand sequences for
// pending-garbage ordering, saturation and mid-operation reset.
module tb_row_op_sched;

    localparam int FC = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [199:0] occupied_bind = '0;
    logic         garb_in_valid = 1'b0;
    logic [4:0]   garb_in_lines = '0;
    logic [3:0]   garb_hole = '0;
    logic         row_we;
    logic [4:0]   row_addr;
    logic [9:0]   row_wdata;
    logic [19:0]  elimination_enable;
    logic [2:0]   lines_cleared;
    logic [4:0]   garb_pending;
    logic         attack_valid;
    logic [2:0]   attack_lines;
    logic         busy;
    logic         done;
    logic         topout;

    row_op_sched #(.FLASH_CYCLES(FC), .MAX_PENDING(20), .MAX_INSERT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .occupied_bind(occupied_bind),
        .garb_in_valid(garb_in_valid), .garb_in_lines(garb_in_lines), .garb_hole(garb_hole),
        .row_we(row_we), .row_addr(row_addr), .row_wdata(row_wdata),
        .elimination_enable(elimination_enable), .lines_cleared(lines_cleared),
        .garb_pending(garb_pending), .attack_valid(attack_valid), .attack_lines(attack_lines),
        .busy(busy), .done(done), .topout(topout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [199:0] board;
        logic [4:0]   pend_in;
        logic [3:0]   hole;
        logic [2:0]   exp_lines;
        logic [2:0]   exp_atk;
        logic [19:0]  exp_mask;
        logic [4:0]   exp_pend;
        logic         exp_topout;
        int           exp_writes;
        int           exp_cycles;
        logic [199:0] exp_image;
    } vec_t;

    vec_t vecs[8];
    int total = 0;
    int bad = 0;

    int           obs_cycles, obs_writes, obs_atk_pulses, obs_flash, obs_done_busy;
    int           bus_bad = 0;
    logic [2:0]   obs_atk_lines;
    logic [19:0]  obs_mask;
    logic [199:0] obs_image;

    function automatic logic [199:0] put(input logic [199:0] b, input int r, input logic [9:0] v);
        b[r*10 +: 10] = v;
        return b;
    endfunction

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        garb_in_valid = 1'b0;
        garb_in_lines = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic add_garb(input logic [4:0] n);
        garb_in_valid = 1'b1;
        garb_in_lines = n;
        @(negedge clk);
        garb_in_valid = 1'b0;
        garb_in_lines = '0;
        @(negedge clk);
    endtask

    // Runs one placement; c counts posedges since the start was sampled.
    task automatic run_op(input logic [199:0] b, input int inj_cyc, input logic [4:0] inj_lines,
                          input int restart_cyc);
        obs_cycles = -1; obs_writes = 0; obs_atk_pulses = 0; obs_flash = 0;
        obs_done_busy = -1; obs_atk_lines = '0; obs_mask = '0; obs_image = '0;
        occupied_bind = b;
        start = 1'b1;
        @(negedge clk);
        occupied_bind = ~b;
        for (int c = 1; c <= 300; c++) begin
            start = (c == restart_cyc);
            garb_in_valid = (c == inj_cyc);
            garb_in_lines = (c == inj_cyc) ? inj_lines : 5'd0;
            if (row_we) begin
                obs_writes++;
                if (row_addr < 5'd20) obs_image[int'(row_addr)*10 +: 10] = row_wdata;
            end else if (row_addr != '0 || row_wdata != '0) begin
                bus_bad++;
            end
            if (attack_valid) begin
                obs_atk_pulses++;
                obs_atk_lines = attack_lines;
            end
            if (elimination_enable != '0) begin
                obs_flash++;
                obs_mask = elimination_enable;
            end
            if (done) begin
                obs_cycles = c;
                obs_done_busy = int'(busy);
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        garb_in_valid = 1'b0;
        garb_in_lines = '0;
    endtask

    logic [199:0] b, img, four;
    int found, w;

    initial begin
        // V0: empty board
        vecs[0] = '{board:'0, pend_in:0, hole:0, exp_lines:0, exp_atk:0, exp_mask:0,
                    exp_pend:0, exp_topout:0, exp_writes:0, exp_cycles:4, exp_image:'0};
        // V1: rows 19,17 full, row 18 = 001
        b = put('0, 19, 10'h3FF); b = put(b, 18, 10'h001); b = put(b, 17, 10'h3FF);
        b = put(b, 16, 10'h0AA); b = put(b, 15, 10'h055);
        img = put('0, 19, 10'h001); img = put(img, 18, 10'h0AA); img = put(img, 17, 10'h055);
        vecs[1] = '{board:b, pend_in:0, hole:0, exp_lines:2, exp_atk:1, exp_mask:20'hA0000,
                    exp_pend:0, exp_topout:0, exp_writes:20, exp_cycles:27, exp_image:img};
        // V2: rows 16..19 full, pending 3 cancels 3 of 4
        four = put('0, 19, 10'h3FF); four = put(four, 18, 10'h3FF);
        four = put(four, 17, 10'h3FF); four = put(four, 16, 10'h3FF);
        b = put(four, 15, 10'h123);
        vecs[2] = '{board:b, pend_in:3, hole:0, exp_lines:4, exp_atk:1, exp_mask:20'hF0000,
                    exp_pend:0, exp_topout:0, exp_writes:20, exp_cycles:27,
                    exp_image:put('0, 19, 10'h123)};
        // V3: no clear, pending 10, hole 4, row 0 non-empty -> topout
        b = put('0, 0, 10'h001); b = put(b, 10, 10'h0F0);
        img = put('0, 2, 10'h0F0);
        for (int r = 12; r < 20; r++) img = put(img, r, 10'h3EF);
        vecs[3] = '{board:b, pend_in:10, hole:4, exp_lines:0, exp_atk:0, exp_mask:0,
                    exp_pend:2, exp_topout:1, exp_writes:20, exp_cycles:24, exp_image:img};
        // V4: no clear, pending 5, hole 12 clamps to 9
        b = put('0, 19, 10'h001);
        img = put('0, 14, 10'h001);
        for (int r = 15; r < 20; r++) img = put(img, r, 10'h1FF);
        vecs[4] = '{board:b, pend_in:5, hole:12, exp_lines:0, exp_atk:0, exp_mask:0,
                    exp_pend:0, exp_topout:0, exp_writes:20, exp_cycles:24, exp_image:img};
        // V5: single clear keeps pending, no garbage phase
        b = put('0, 19, 10'h3FF); b = put(b, 18, 10'h00F);
        vecs[5] = '{board:b, pend_in:2, hole:0, exp_lines:1, exp_atk:0, exp_mask:20'h80000,
                    exp_pend:2, exp_topout:0, exp_writes:20, exp_cycles:27,
                    exp_image:put('0, 19, 10'h00F)};
        // V6: triple clear
        b = put('0, 19, 10'h3FF); b = put(b, 18, 10'h3FF); b = put(b, 17, 10'h3FF);
        b = put(b, 16, 10'h200);
        vecs[6] = '{board:b, pend_in:0, hole:0, exp_lines:3, exp_atk:2, exp_mask:20'hE0000,
                    exp_pend:0, exp_topout:0, exp_writes:20, exp_cycles:27,
                    exp_image:put('0, 19, 10'h200)};
        // V7: top row full; rows below stay put, row 0 refills with zero
        b = put('0, 0, 10'h3FF); b = put(b, 19, 10'h3FE); b = put(b, 5, 10'h111);
        img = put('0, 19, 10'h3FE); img = put(img, 5, 10'h111);
        vecs[7] = '{board:b, pend_in:0, hole:0, exp_lines:1, exp_atk:0, exp_mask:20'h00001,
                    exp_pend:0, exp_topout:0, exp_writes:20, exp_cycles:27, exp_image:img};

        @(negedge clk);
        chk("reset outputs", 200'({row_we, row_addr, row_wdata, elimination_enable, lines_cleared,
            garb_pending, attack_valid, attack_lines, busy, done, topout}), '0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            garb_hole = vecs[i].hole;
            if (vecs[i].pend_in != '0) add_garb(vecs[i].pend_in);
            chk($sformatf("v%0d preload", i), 200'(garb_pending), 200'(vecs[i].pend_in));
            run_op(vecs[i].board, -1, '0, -1);
            chk($sformatf("v%0d latency", i), 200'(obs_cycles), 200'(vecs[i].exp_cycles));
            chk($sformatf("v%0d writes", i), 200'(obs_writes), 200'(vecs[i].exp_writes));
            chk($sformatf("v%0d image", i), obs_image, vecs[i].exp_image);
            chk($sformatf("v%0d lines", i), 200'(lines_cleared), 200'(vecs[i].exp_lines));
            chk($sformatf("v%0d attack pulses", i), 200'(obs_atk_pulses),
                200'((vecs[i].exp_atk != 3'd0) ? 1 : 0));
            chk($sformatf("v%0d attack lines", i), 200'(obs_atk_lines), 200'(vecs[i].exp_atk));
            chk($sformatf("v%0d mask", i), 200'(obs_mask), 200'(vecs[i].exp_mask));
            chk($sformatf("v%0d flash len", i), 200'(obs_flash),
                200'((vecs[i].exp_mask != '0) ? FC : 0));
            chk($sformatf("v%0d pending", i), 200'(garb_pending), 200'(vecs[i].exp_pend));
            chk($sformatf("v%0d topout", i), 200'(topout), 200'(vecs[i].exp_topout));
            chk($sformatf("v%0d busy at done", i), 200'(obs_done_busy), '0);
        end

        // Saturation of queued garbage
        do_reset();
        add_garb(5'd15);
        chk("sat first", 200'(garb_pending), 200'(15));
        add_garb(5'd15);
        chk("sat second", 200'(garb_pending), 200'(20));

        // Quad clear from pending 20 with +10 arriving in ATTACK: 20-4+10 -> 20.
        // A stray start during COMPACT must be ignored.
        do_reset();
        add_garb(5'd20);
        run_op(four, 25, 5'd10, 10);
        chk("order clear pending", 200'(garb_pending), 200'(20));
        chk("order clear attack", 200'(obs_atk_pulses), '0);
        chk("restart ignored writes", 200'(obs_writes), 200'(20));
        chk("restart ignored latency", 200'(obs_cycles), 200'(27));
        chk("restart ignored image", obs_image, '0);

        // No clear, pending 10, +15 arriving in ATTACK: 10-8+15 -> 17.
        do_reset();
        garb_hole = 4'd0;
        add_garb(5'd10);
        run_op('0, 2, 5'd15, -1);
        img = '0;
        for (int r = 12; r < 20; r++) img = put(img, r, 10'h3FE);
        chk("order garb pending", 200'(garb_pending), 200'(17));
        chk("order garb image", obs_image, img);
        chk("order garb topout", 200'(topout), '0);

        // Reset in the middle of COMPACT
        do_reset();
        occupied_bind = vecs[1].board;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (row_we && row_addr == 5'd10) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reach dst 10", 200'(found), 200'(1));
        rst = 1'b0;
        #1;
        chk("abort outputs", 200'({row_we, row_addr, row_wdata, elimination_enable, lines_cleared,
            garb_pending, attack_valid, attack_lines, busy, done, topout}), '0);
        w = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (row_we) w++;
        end
        chk("abort no writes", 200'(w), '0);
        rst = 1'b1;
        @(negedge clk);
        run_op('0, -1, '0, -1);
        chk("after abort latency", 200'(obs_cycles), 200'(4));
        chk("after abort writes", 200'(obs_writes), '0);

        chk("idle bus quiet", 200'(bus_bad), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
